// File: rtl/exec_stage_pipe.sv
`default_nettype none
// ============================================================================
// exec_stage_pipe : pipelined execute stage with EX/MEM + MEM/WB forwarding
//                   and an iterative shift-add multiplier
// Revision        : 1.0
// ============================================================================
module exec_stage_pipe #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [RA_W-1:0]  in_rs1,
    input  logic [RA_W-1:0]  in_rs2,
    input  logic             in_use1,
    input  logic             in_use2,
    input  logic [RA_W-1:0]  in_rd,
    input  logic             in_wr_en,
    input  logic             wb_wr_en,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RA_W-1:0]  out_rd,
    output logic             out_wr_en,
    output logic             out_zero,
    output logic             out_ofl
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;

    localparam logic [3:0] c_OP_ADD = 4'd0,  c_OP_SUB = 4'd1,  c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_OR  = 4'd3,  c_OP_XOR = 4'd4,  c_OP_SLL = 4'd5;
    localparam logic [3:0] c_OP_SRL = 4'd6,  c_OP_ROL = 4'd7,  c_OP_ROR = 4'd8;
    localparam logic [3:0] c_OP_SLT = 4'd9,  c_OP_SEQ = 4'd10, c_OP_SCO = 4'd11;
    localparam logic [3:0] c_OP_MUL = 4'd12, c_OP_PSB = 4'd13;

    localparam logic [SH_W-1:0] c_LAST = SH_W'(WIDTH - 1);
    localparam logic [SH_W:0]   c_W    = (SH_W + 1)'(WIDTH);

    typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;

    state_t             state_q, state_d;
    logic [SH_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [RA_W-1:0]    mrd_q, mrd_d;
    logic               mwr_q, mwr_d;
    logic               ov_q, ov_d, owr_q, owr_d, oz_q, oz_d, oofl_q, oofl_d;
    logic [WIDTH-1:0]   ores_q, ores_d;
    logic [RA_W-1:0]    ord_q, ord_d;

    logic [WIDTH-1:0]   w_fa, w_fb, w_diff, w_alu, w_acc_nxt;
    logic [WIDTH:0]     w_sum;
    logic [SH_W-1:0]    w_sh;
    logic [SH_W:0]      w_rsh;
    logic               w_ofl, w_accept;

    // EX/MEM result takes priority over MEM/WB because it is the younger write
    assign w_fa = (in_use1 && ov_q && owr_q && (ord_q == in_rs1)) ? ores_q :
                  (in_use1 && wb_wr_en && (wb_rd == in_rs1))      ? wb_data : in_a;
    assign w_fb = (in_use2 && ov_q && owr_q && (ord_q == in_rs2)) ? ores_q :
                  (in_use2 && wb_wr_en && (wb_rd == in_rs2))      ? wb_data : in_b;

    assign in_ready = (state_q == ST_IDLE) && (!ov_q || out_ready) && !flush;
    assign w_accept = in_valid && in_ready;

    assign w_sum     = {1'b0, w_fa} + {1'b0, w_fb};
    assign w_diff    = w_fa - w_fb;
    assign w_sh      = w_fb[SH_W-1:0];
    assign w_rsh     = c_W - {1'b0, w_sh};
    assign w_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        w_alu = '0;
        w_ofl = 1'b0;
        case (in_op)
            c_OP_ADD: begin
                w_alu = w_sum[MSB:0];
                w_ofl = (w_fa[MSB] == w_fb[MSB]) && (w_sum[MSB] != w_fa[MSB]);
            end
            c_OP_SUB: begin
                w_alu = w_diff;
                w_ofl = (w_fa[MSB] != w_fb[MSB]) && (w_diff[MSB] != w_fa[MSB]);
            end
            c_OP_AND: w_alu = w_fa & w_fb;
            c_OP_OR:  w_alu = w_fa | w_fb;
            c_OP_XOR: w_alu = w_fa ^ w_fb;
            c_OP_SLL: w_alu = w_fa << w_sh;
            c_OP_SRL: w_alu = w_fa >> w_sh;
            // a shift by the full width yields zero, so rotate-by-0 falls out naturally
            c_OP_ROL: w_alu = (w_fa << w_sh) | (w_fa >> w_rsh);
            c_OP_ROR: w_alu = (w_fa >> w_sh) | (w_fa << w_rsh);
            c_OP_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_fa) < $signed(w_fb))};
            c_OP_SEQ: w_alu = {{(WIDTH-1){1'b0}}, (w_fa == w_fb)};
            c_OP_SCO: w_alu = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
            c_OP_PSB: w_alu = w_fb;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        mrd_d    = mrd_q;
        mwr_d    = mwr_q;
        ov_d     = ov_q;
        ores_d   = ores_q;
        ord_d    = ord_q;
        owr_d    = owr_q;
        oz_d     = oz_q;
        oofl_d   = oofl_q;
        if (flush) begin
            state_d = ST_IDLE;
            ov_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            if (ov_q && out_ready) ov_d = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept && (in_op == c_OP_MUL)) begin
                        mcand_d  = w_fa;
                        mplier_d = w_fb;
                        acc_d    = '0;
                        cnt_d    = '0;
                        mrd_d    = in_rd;
                        mwr_d    = in_wr_en;
                        ov_d     = 1'b0;
                        state_d  = ST_MUL;
                    end else if (w_accept) begin
                        ov_d   = 1'b1;
                        ores_d = w_alu;
                        ord_d  = in_rd;
                        owr_d  = in_wr_en && (in_op[3:1] != 3'b111);
                        oz_d   = (w_alu == '0);
                        oofl_d = w_ofl;
                    end
                end
                ST_MUL: begin
                    acc_d    = w_acc_nxt;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == c_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        ov_d    = 1'b1;
                        ores_d  = w_acc_nxt;
                        ord_d   = mrd_q;
                        owr_d   = mwr_q;
                        oz_d    = (w_acc_nxt == '0);
                        oofl_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            mrd_q    <= '0;
            mwr_q    <= 1'b0;
            ov_q     <= 1'b0;
            ores_q   <= '0;
            ord_q    <= '0;
            owr_q    <= 1'b0;
            oz_q     <= 1'b0;
            oofl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            mrd_q    <= mrd_d;
            mwr_q    <= mwr_d;
            ov_q     <= ov_d;
            ores_q   <= ores_d;
            ord_q    <= ord_d;
            owr_q    <= owr_d;
            oz_q     <= oz_d;
            oofl_q   <= oofl_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_result = ores_q;
    assign out_rd     = ord_q;
    assign out_wr_en  = owr_q;
    assign out_zero   = oz_q;
    assign out_ofl    = oofl_q;

endmodule
`default_nettype wire

// File: doc/exec_stage_pipe.md
# exec_stage_pipe

Parametrised, pipelined execute stage for the WISC-style core. It sits between the ID/EX and EX/MEM boundaries and accepts one decoded operation per cycle over a valid/ready handshake. It resolves operand forwarding from its own output register (EX/MEM) and from an external MEM/WB port, then computes single-cycle ALU/shift/set results or a multi-cycle iterative multiply. The result is held in a registered EX/MEM output with backpressure.

## Interface
- WIDTH, 16: datapath width; must be a power of 2, ≥ 8.
- RA_W, 3: register-address width.
- SH_W, $clog2(WIDTH): shift-amount width (derived, not overridable).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operation present.
- in_ready  out  1  stage can accept an operation this cycle.
- in_op  in  4  opcode (see Operation).
- in_a, in_b  in  WIDTH  operands as read from the register file.
- in_rs1, in_rs2  in  RA_W  source register numbers for a and b.
- in_use1, in_use2  in  1  operand a / b comes from a register, so forwarding applies.
- in_rd  in  RA_W  destination register; in_wr_en  in  1  writes a register.
- wb_wr_en  in  1, wb_rd  in  RA_W, wb_data  in  WIDTH  MEM/WB forwarding source.
- flush  in  1  synchronous kill of in-flight and held work.
- out_valid  out  1, out_ready  in  1  EX/MEM handshake.
- out_result  out  WIDTH, out_rd  out  RA_W, out_wr_en  out  1, out_zero  out  1, out_ofl  out  1.

## Operation
- Opcodes, all results WIDTH bits, all shifts by b[SH_W-1:0]:
  - 0 ADD: a+b.
  - 1 SUB: a−b.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL (logical), 7 ROL, 8 ROR.
  - 9 SLT: signed a<b → 1, else 0.
  - 10 SEQ: a==b → 1, else 0.
  - 11 SCO: carry-out of a+b → 1, else 0.
  - 12 MUL: low WIDTH bits of a×b, unsigned.
  - 13 PASSB: b.
  - 14–15: result 0, out_wr_en forced 0.
- out_ofl is signed overflow for ADD/SUB only; 0 for all other ops. out_zero = (out_result==0).
- Forwarding per operand, applied only when the matching use bit is set, in priority order:
  1. out register, when out_valid && out_wr_en && out_rd==rs.
  2. MEM/WB, when wb_wr_en && wb_rd==rs.
  3. The raw in_a / in_b.
  - Register 0 has no special treatment.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Acceptance happens when in_valid && in_ready. Forwarded operands are captured at acceptance.
- FSM:
  - IDLE: a non-MUL op loads the out register and sets out_valid. MUL captures operands, clears the counter, clears out_valid, and moves to MUL.
  - MUL: shift-add, one bit per cycle, WIDTH iterations. On the last iteration it loads the out register, sets out_valid, and returns to IDLE.
- out_valid && out_ready with no new acceptance → out_valid drops. The out_* fields keep their values.
- flush: next edge → state IDLE, out_valid 0, any MUL discarded, no acceptance that cycle. Flush wins over every simultaneous event.
- Reset mid-operation: all state is cleared immediately and asynchronously; a partial MUL is lost.

## Timing
- Reset values: out_valid 0, out_result 0, out_rd 0, out_wr_en 0, out_zero 0, out_ofl 0, state IDLE, MUL counter 0. in_ready = 1 in the first cycle after rst_n rises.
- Single-cycle op accepted at edge N → out_valid = 1 after edge N. Back-to-back throughput is one op per cycle while out_ready = 1.
- MUL accepted at edge N:
  - in_ready = 0 for cycles N+1 … N+WIDTH.
  - out_valid = 1 after edge N+WIDTH.
  - in_ready returns to 1 after edge N+WIDTH if out_ready = 1.
- Backpressure: while out_valid && !out_ready, all out_* fields are stable and in_ready = 0.
- Forward paths are combinational from the out register and wb_* to the operand capture. The stage adds no bubble for dependent ops.

## Test plan
- ADD a=0x7FFF, b=0x0001 → out_result 0x8000, out_ofl 1, out_zero 0, one cycle after acceptance. SUB 0x0005−0x0005 → 0x0000, out_zero 1.
- Shifts:
  - ROR 0x0001 by 1 → 0x8000.
  - ROL 0x8001 by 4 → 0x0018.
  - SRL 0x8000 by 15 → 0x0001.
  - SLT 0xFFFF vs 0x0001 → 1.
- MUL 0x0012×0x0034 → 0x03A8. in_ready is low for exactly 16 cycles and out_valid rises 16 edges after acceptance. MUL 0xFFFF×0x0002 → 0xFFFE.
- Forwarding sequence:
  - ADD rd=3 (a=2, b=3) → 5.
  - Next cycle ADD rs1=3 with in_a=0 (stale), b=1, use1=1 → 6.
  - Repeat with wb_rd=3, wb_data=0x0100 also valid → still 6 (EX/MEM wins).
  - With out_valid=0 the same case → 0x0101 (MEM/WB used).
- Backpressure: out_ready held 0 for 5 cycles with in_valid=1 → in_ready stays 0 and out_result is unchanged. The next op is accepted on the cycle out_ready=1.
- Abort cases:
  - flush 5 cycles into a MUL → out_valid never rises and in_ready = 1 the next cycle.
  - rst_n pulsed low during a MUL → all outputs 0 immediately and in_ready = 1 after release.
